polyphase_tx_commutator: RTL and testbench

//  Output commutator of the Tx polyphase interpolator: gathers one sample per branch from the
//  NUM_BRANCH Tx FIR branches into a frame, buffers whole frames, and serializes each frame

---
 rtl/poly_tx_pkg.sv | 16 +
 rtl/poly_tx_frame_fifo.sv | 53 +++++
 rtl/polyphase_tx_commutator.sv | 141 ++++++++++++++
 tb/tb_polyphase_tx_commutator.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_tx_pkg.sv
// Shared types and defaults for the Tx polyphase output commutator.
package poly_tx_pkg;

  localparam int unsigned NUM_BRANCH_DEF = 8;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned DROP_CNT_W     = 16;

  typedef logic signed [DATA_W_DEF-1:0] sample_t;
  typedef sample_t [NUM_BRANCH_DEF-1:0] frame_t;

  typedef enum logic [0:0] {
    IDLE,
    STREAM
  } state_e;

endpackage

// File: rtl/poly_tx_frame_fifo.sv
// Synchronous whole-frame FIFO; head is read straight from the storage registers so a frame
// pushed at an edge is presentable in the very next cycle.
module poly_tx_frame_fifo #(
  parameter int unsigned Width = 256,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  // A push into a full FIFO is accepted only when the same edge frees the head slot.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AddrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/polyphase_tx_commutator.sv
// Tx polyphase output commutator: branch capture, frame FIFO, AXI-Stream serializer.
// Optional POLY_TX_DROP_CNT_EN adds a saturating drop_count output.
module polyphase_tx_commutator
  import poly_tx_pkg::*;
#(
  parameter int unsigned NUM_BRANCH = NUM_BRANCH_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic signed [NUM_BRANCH-1:0][DATA_W-1:0] branch_data,
  input  logic [NUM_BRANCH-1:0]                  branch_tvalid,
  output logic signed [DATA_W-1:0]               m_axis_tdata,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic                                   m_axis_tlast,
  output logic                                   frame_full,
  output logic                                   overflow_err
`ifdef POLY_TX_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]                  drop_count
`endif
);

  localparam int unsigned IdxW = $clog2(NUM_BRANCH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BRANCH - 1);

  logic [NUM_BRANCH-1:0]              flag_q, flag_d, drop_vec;
  logic [NUM_BRANCH-1:0][DATA_W-1:0]  hold_q, hold_d, head;
  logic                               push, pop, full, empty;
  logic [CntW-1:0]                    count;
  state_e                             state_q;
  logic [IdxW-1:0]                    idx_q;

  assign push = (&flag_q) & ~full;

  // A push frees every slot, so samples arriving in the push cycle seed the next frame.
  always_comb begin
    flag_d   = push ? '0 : flag_q;
    hold_d   = hold_q;
    drop_vec = '0;
    for (int i = 0; i < NUM_BRANCH; i++) begin
      if (branch_tvalid[i]) begin
        if (!flag_d[i]) begin
          hold_d[i] = branch_data[i];
          flag_d[i] = 1'b1;
        end else begin
          drop_vec[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q       <= '0;
      hold_q       <= '0;
      overflow_err <= 1'b0;
    end else begin
      flag_q       <= flag_d;
      hold_q       <= hold_d;
      overflow_err <= overflow_err | (|drop_vec);
    end
  end

  poly_tx_frame_fifo #(
    .Width (NUM_BRANCH * DATA_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (hold_q),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign pop = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // Leaving IDLE on the push edge itself gives first tvalid two cycles after the last branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty || push) begin
            state_q <= STREAM;
            idx_q   <= '0;
          end
        end
        STREAM: begin
          if (m_axis_tready) begin
            if (idx_q == LastIdx) begin
              idx_q <= '0;
              if (count == CntW'(1) && !push) state_q <= IDLE;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis_tvalid = (state_q == STREAM);
  assign m_axis_tlast  = (state_q == STREAM) && (idx_q == LastIdx);
  assign m_axis_tdata  = head[idx_q];
  assign frame_full    = full;

`ifdef POLY_TX_DROP_CNT_EN
  localparam int unsigned DropNumW = $clog2(NUM_BRANCH + 1);

  logic [DropNumW-1:0]   drop_num;
  logic [DROP_CNT_W:0]   drop_sum;

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < NUM_BRANCH; i++) begin
      drop_num = drop_num + DropNumW'(drop_vec[i]);
    end
    drop_sum = {1'b0, drop_count} + (DROP_CNT_W + 1)'(drop_num);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else begin
      drop_count <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_polyphase_tx_commutator.sv
// Self-checking bench for polyphase_tx_commutator against a frame-queue reference model.
module tb_polyphase_tx_commutator;

  localparam int N     = 8;
  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic signed [N-1:0][W-1:0] branch_data;
  logic [N-1:0]               branch_tvalid;
  logic signed [W-1:0]        m_axis_tdata;
  logic                       m_axis_tvalid;
  logic                       m_axis_tready;
  logic                       m_axis_tlast;
  logic                       frame_full;
  logic                       overflow_err;
`ifdef POLY_TX_DROP_CNT_EN
  logic [15:0]                drop_count;
`endif

  polyphase_tx_commutator #(
    .NUM_BRANCH (N),
    .DATA_W     (W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .branch_data   (branch_data),
    .branch_tvalid (branch_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .frame_full    (frame_full),
    .overflow_err  (overflow_err)
`ifdef POLY_TX_DROP_CNT_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: capture slots, count of buffered frames, flattened expected output.
  logic [W-1:0] m_hold [N];
  bit           m_flag [N];
  logic [W-1:0] out_q [$];
  int           occ;
  int           out_pos;
  int           m_drops;
  bit           m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_hold[i] = '0;
      m_flag[i] = 1'b0;
    end
    out_q.delete();
    occ     = 0;
    out_pos = 0;
    m_drops = 0;
    m_ovf   = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, advance the model, return just after rise.
  task automatic step();
    bit exp_tvalid, hs, push, all_set;
    int ndrop;
    @(negedge clk);
    exp_tvalid = (occ > 0);
    check_eq("tvalid", m_axis_tvalid, exp_tvalid);
    check_eq("tlast", m_axis_tlast, exp_tvalid && (out_pos == N - 1));
    if (exp_tvalid) check_eq("tdata", m_axis_tdata, out_q[0]);
    check_eq("frame_full", frame_full, occ == DEPTH);
    check_eq("overflow_err", overflow_err, m_ovf);
`ifdef POLY_TX_DROP_CNT_EN
    check_eq("drop_count", drop_count, m_drops);
`endif
    hs      = exp_tvalid && m_axis_tready;
    all_set = 1'b1;
    for (int i = 0; i < N; i++) all_set &= m_flag[i];
    push = all_set && (occ < DEPTH);
    if (hs) begin
      void'(out_q.pop_front());
      out_pos++;
      if (out_pos == N) begin
        out_pos = 0;
        occ--;
      end
    end
    if (push) begin
      for (int i = 0; i < N; i++) begin
        out_q.push_back(m_hold[i]);
        m_flag[i] = 1'b0;
      end
      occ++;
    end
    ndrop = 0;
    for (int i = 0; i < N; i++) begin
      if (branch_tvalid[i]) begin
        if (!m_flag[i]) begin
          m_hold[i] = branch_data[i];
          m_flag[i] = 1'b1;
        end else begin
          ndrop++;
        end
      end
    end
    m_drops = (m_drops + ndrop > 65535) ? 65535 : m_drops + ndrop;
    if (ndrop > 0) m_ovf = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] mask, input int base);
    branch_tvalid = mask;
    for (int i = 0; i < N; i++) branch_data[i] = base + i;
    step();
    branch_tvalid = '0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    branch_tvalid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst           = 1'b1;
    branch_tvalid = '0;
    branch_data   = '0;
    m_axis_tready = 1'b1;
    model_reset();
    @(negedge clk);
    check_eq("rst_tvalid", m_axis_tvalid, 1'b0);
    check_eq("rst_tlast", m_axis_tlast, 1'b0);
    check_eq("rst_tdata", m_axis_tdata, 32'd0);
    check_eq("rst_full", frame_full, 1'b0);
    check_eq("rst_ovf", overflow_err, 1'b0);
    do_reset();

    // 1: all branches in one cycle
    drive('1, 100);
    idle(12);

    // 2: staggered branches
    for (int c = 0; c < N; c++) drive(N'(1) << c, 10);
    idle(14);

    // 3: stalled sink, six frames offered
    m_axis_tready = 1'b0;
    for (int f = 0; f < 6; f++) drive('1, 1000 + 8 * f);
    idle(14);
    check_eq("t3_full", frame_full, 1'b1);
    check_eq("t3_ovf", overflow_err, 1'b1);
`ifdef POLY_TX_DROP_CNT_EN
    check_eq("t3_drops", drop_count, 16'd8);
`endif
    m_axis_tready = 1'b1;
    idle(50);

    // 4: repeated branch before frame completes
    do_reset();
    drive(8'b0000_1000, 2);
    drive(8'b0000_1000, 6);
    drive(8'b1111_0111, 50);
    idle(14);
    check_eq("t4_ovf", overflow_err, 1'b1);
`ifdef POLY_TX_DROP_CNT_EN
    check_eq("t4_drops", drop_count, 16'd1);
`endif

    // 5: toggling ready
    do_reset();
    for (int f = 0; f < 3; f++) begin
      m_axis_tready = f[0];
      drive('1, 2000 + 8 * f);
    end
    for (int k = 0; k < 60; k++) begin
      m_axis_tready = k[0];
      step();
    end
    m_axis_tready = 1'b1;
    idle(10);

    // 6: asynchronous reset mid-frame
    drive('1, 200);
    for (int k = 0; k < 20 && !(occ > 0 && out_pos == 3); k++) step();
    check_eq("t6_idx_reached", out_pos, 3);
    #1 rst = 1'b1;
    #1;
    check_eq("t6_async_tvalid", m_axis_tvalid, 1'b0);
    check_eq("t6_async_full", frame_full, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle(3);
    drive('1, 300);
    idle(12);

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 400; k++) begin
      m_axis_tready = ($urandom_range(0, 3) != 0);
      branch_tvalid = '0;
      for (int i = 0; i < N; i++) begin
        branch_tvalid[i] = ($urandom_range(0, 2) == 0);
        branch_data[i]   = $urandom;
      end
      step();
    end
    branch_tvalid = '0;
    m_axis_tready = 1'b1;
    idle(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
